// File: rtl/cpu_mem_sequencer_pkg.sv
// Shared encodings for the CPU memory sequencer: FSM states and bus address-select values.
package cpu_mem_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_COMMIT = 3'd4,
        ST_ERROR  = 3'd5
    } seq_state_t;

    localparam logic BUS_SEL_PC  = 1'b0;
    localparam logic BUS_SEL_ALU = 1'b1;

    function automatic logic is_bus_state(input seq_state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/cpu_mem_sequencer_seq_wait_timer.sv
// Bus wait-state counter: saturating, cleared outside bus states and on ready, flags expiry.
module seq_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] CNT_MAX  = '1;

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!active || ready) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    // A ready in the expiring cycle takes priority, hence the ~ready term.
    assign expired = (TIMEOUT_CYCLES != 0) && active && !ready && (cnt_q == CNT_LAST);

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Multi-cycle fetch/decode/mem/commit sequencer sharing one MIO bus port, with bus timeout.
//   state  | meaning
//   IDLE   | halted at an instruction boundary, waiting for run
//   FETCH  | instruction read from PC, stalls on MIO_ready
//   DECODE | one cycle, latches store/regwrite decode
//   MEM    | load/store data access at ALU address, stalls on MIO_ready
//   COMMIT | single-cycle PC and register-file write
//   ERROR  | bus timed out, left only by reset
module cpu_mem_sequencer
    import cpu_mem_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic CPU_MIO,
    input  logic MemRW,
    input  logic RegWrite,
    input  logic MIO_ready,
    output logic bus_req,
    output logic bus_sel,
    output logic bus_we,
    output logic ir_we,
    output logic mdr_we,
    output logic pc_we,
    output logic rf_we,
    output logic busy,
    output logic timeout_err
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       mem_rw_q;
    logic       rf_q;
    logic       expired;
    logic       bus_active;

    assign bus_active = is_bus_state(state_q);

    seq_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (bus_active),
        .ready  (MIO_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mem_rw_q <= 1'b0;
            rf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                // Undefined decoder outputs fall into the else branch: plain NOP commit.
                if (MemRW == 1'b1) mem_rw_q <= 1'b1;
                else               mem_rw_q <= 1'b0;
                if (RegWrite == 1'b1) rf_q <= 1'b1;
                else                  rf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_req     = 1'b0;
        bus_sel     = BUS_SEL_PC;
        bus_we      = 1'b0;
        ir_we       = 1'b0;
        mdr_we      = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        busy        = 1'b1;
        timeout_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                bus_req = 1'b1;
                ir_we   = MIO_ready;
                if (MIO_ready)    state_d = ST_DECODE;
                else if (expired) state_d = ST_ERROR;
            end
            ST_DECODE: begin
                if (CPU_MIO == 1'b1) state_d = ST_MEM;
                else                 state_d = ST_COMMIT;
            end
            ST_MEM: begin
                bus_req = 1'b1;
                bus_sel = BUS_SEL_ALU;
                bus_we  = mem_rw_q;
                mdr_we  = MIO_ready & ~mem_rw_q;
                if (MIO_ready)    state_d = ST_COMMIT;
                else if (expired) state_d = ST_ERROR;
            end
            ST_COMMIT: begin
                pc_we   = 1'b1;
                rf_we   = rf_q;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_ERROR: begin
                busy        = 1'b0;
                timeout_err = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Randomized instruction stream with a reactive bus model; scoreboard checks each commit.
module tb_cpu_mem_sequencer;

    localparam int TMO = 6;
    localparam int N   = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic CPU_MIO = 1'b0;
    logic MemRW = 1'b0;
    logic RegWrite = 1'b0;
    logic MIO_ready = 1'b0;
    logic bus_req, bus_sel, bus_we, ir_we, mdr_we, pc_we, rf_we, busy, timeout_err;

    always #5 clk = ~clk;

    cpu_mem_sequencer #(.TIMEOUT_CYCLES(TMO), .TO_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .CPU_MIO    (CPU_MIO),
        .MemRW      (MemRW),
        .RegWrite   (RegWrite),
        .MIO_ready  (MIO_ready),
        .bus_req    (bus_req),
        .bus_sel    (bus_sel),
        .bus_we     (bus_we),
        .ir_we      (ir_we),
        .mdr_we     (mdr_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    typedef struct {
        int   lat;
        int   ir;
        int   sel1;
        int   we;
        int   mdr;
        logic rw;
        logic halt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    bit p_mem[N], p_st[N], p_rw[N], p_halt[N];
    int p_fw[N], p_mw[N];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected behaviour straight from the latency and strobe rules of each instruction class.
    function automatic exp_t model(input int i);
        exp_t e;
        e.lat  = 3 + p_fw[i] + (p_mem[i] ? 1 + p_mw[i] : 0);
        e.ir   = 1;
        e.sel1 = p_mem[i] ? 1 + p_mw[i] : 0;
        e.we   = (p_mem[i] && p_st[i]) ? 1 + p_mw[i] : 0;
        e.mdr  = (p_mem[i] && !p_st[i]) ? 1 : 0;
        e.rw   = p_rw[i];
        e.halt = p_halt[i];
        return e;
    endfunction

    // Monitor: accumulates strobe activity per instruction and checks it at COMMIT.
    bit   m_inf = 1'b0;
    bit   m_chk_halt = 1'b0;
    bit   m_last_halt = 1'b0;
    int   m_lat, m_ir, m_sel1, m_we, m_mdr;
    exp_t m_e;

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (m_chk_halt) begin
                m_chk_halt = 1'b0;
                check("busy_after_commit", int'(busy), int'(!m_last_halt));
            end
            if (!m_inf && bus_req && !bus_sel) begin
                m_inf = 1'b1;
                m_lat = 0; m_ir = 0; m_sel1 = 0; m_we = 0; m_mdr = 0;
            end
            if (m_inf) begin
                m_lat++;
                m_ir   += int'(ir_we);
                m_sel1 += int'(bus_req && bus_sel);
                m_we   += int'(bus_we);
                m_mdr  += int'(mdr_we);
            end
            if (rf_we && !pc_we) check("rf_we_outside_commit", 1, 0);
            if (pc_we) begin
                if (sbq.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    m_e = sbq.pop_front();
                    check("latency", m_lat, m_e.lat);
                    check("ir_we_pulses", m_ir, m_e.ir);
                    check("bus_sel_data_cycles", m_sel1, m_e.sel1);
                    check("bus_we_cycles", m_we, m_e.we);
                    check("mdr_we_pulses", m_mdr, m_e.mdr);
                    check("rf_we_at_commit", int'(rf_we), int'(m_e.rw));
                    m_chk_halt  = 1'b1;
                    m_last_halt = m_e.halt;
                end
                m_inf = 1'b0;
            end
        end
    end

    initial begin
        int fidx, cur, wcnt, gap, committed, cyc, tgt, kind, w, reqc, lat;
        bit stuck_ok;

        for (int i = 0; i < N; i++) begin
            kind      = int'($urandom_range(0, 2));
            p_mem[i]  = (kind != 0);
            p_st[i]   = (kind == 2);
            p_rw[i]   = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom % 2);
            p_fw[i]   = ($urandom % 4 == 0) ? int'($urandom_range(1, TMO - 1)) : 0;
            p_mw[i]   = ($urandom % 3 == 0) ? int'($urandom_range(1, TMO - 1)) : 0;
            p_halt[i] = ($urandom % 5 == 0);
        end
        p_mem[0] = 0; p_st[0] = 0; p_rw[0] = 1; p_fw[0] = 0; p_mw[0] = 0; p_halt[0] = 0;
        p_mem[1] = 1; p_st[1] = 0; p_rw[1] = 1; p_fw[1] = 0; p_mw[1] = 2; p_halt[1] = 0;
        p_mem[2] = 1; p_st[2] = 1; p_rw[2] = 0; p_fw[2] = 0; p_mw[2] = 0; p_halt[2] = 0;
        p_mem[3] = 0; p_st[3] = 0; p_rw[3] = 0; p_fw[3] = TMO - 1; p_halt[3] = 0;
        p_mem[4] = 1; p_st[4] = 0; p_rw[4] = 1; p_fw[4] = 0; p_mw[4] = TMO - 1; p_halt[4] = 1;
        p_halt[N-1] = 1;

        // Reset state, with inputs pushing toward activity.
        run = 1'b1; MIO_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({bus_req, bus_sel, bus_we, ir_we, mdr_we, pc_we, rf_we, busy, timeout_err}), 0);
        run = 1'b0; MIO_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        fidx = 0; cur = 0; wcnt = 0; gap = 0; committed = 0; cyc = 0;
        run = 1'b1;
        mon_en = 1'b1;
        while (committed < N && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            MIO_ready = 1'($urandom % 2);
            if (bus_req) begin
                if (!bus_sel) begin
                    if (wcnt == 0 && fidx < N) begin
                        sbq.push_back(model(fidx));
                        if (p_halt[fidx] && !p_mem[fidx]) run = 1'b0;
                    end
                    tgt = (fidx < N) ? p_fw[fidx] : 0;
                end else begin
                    if (wcnt == 0 && p_halt[cur]) run = 1'b0;
                    tgt = p_mw[cur];
                end
                if (wcnt >= tgt) begin
                    MIO_ready = 1'b1;
                    wcnt = 0;
                    if (!bus_sel && fidx < N) begin
                        cur = fidx;
                        fidx++;
                        CPU_MIO  = p_mem[cur];
                        MemRW    = p_mem[cur] ? p_st[cur] : 1'($urandom % 2);
                        RegWrite = p_rw[cur];
                    end
                end else begin
                    MIO_ready = 1'b0;
                    wcnt++;
                end
            end
            if (pc_we) begin
                committed++;
                if (!run) gap = 1 + int'($urandom_range(0, 2));
            end else if (gap > 0) begin
                gap--;
                if (gap == 0 && committed < N) run = 1'b1;
            end
        end
        check("all_commits_seen", committed, N);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("scoreboard_drained", sbq.size(), 0);

        // Bus never answers a fetch: expect TMO request cycles then sticky ERROR.
        MIO_ready = 1'b0; CPU_MIO = 1'b0; run = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus_req && w < 10) begin @(negedge clk); w++; end
        reqc = 0;
        while (bus_req && reqc < 20) begin reqc++; @(negedge clk); end
        check("timeout_fetch_cycles", reqc, TMO);
        check("timeout_err_set", int'(timeout_err), 1);
        check("error_busy_low", int'(busy), 0);
        stuck_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            MIO_ready = 1'($urandom % 2);
            @(negedge clk);
            if (!timeout_err || bus_req || pc_we) stuck_ok = 1'b0;
        end
        check("error_sticky", int'(stuck_ok), 1);
        rst_n = 1'b0;
        #1;
        check("reset_clears_error", int'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset in the middle of a stalled fetch, then restart.
        MIO_ready = 1'b0; run = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus_req && w < 10) begin @(negedge clk); w++; end
        check("fetch_before_reset", int'(bus_req && !bus_sel), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drops_req", int'({bus_req, busy, ir_we, pc_we}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("fetch_restart", int'(bus_req && !bus_sel), 1);
        MIO_ready = 1'b1; CPU_MIO = 1'b0; RegWrite = 1'b1;
        lat = 1;
        while (!pc_we && lat < 10) begin @(negedge clk); lat++; end
        check("restart_alu_latency", lat, 3);
        check("restart_rf_we", int'(rf_we), 1);
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
